serial_parity_rx: RTL and testbench
===================================

// Module: serial_parity_rx
// PURPOSE
//  Receiver/checker end of the XOR-parity serial link. It deserialises frames of
//  start bit, DATA_W data bits (LSB first), one parity bit and one stop bit.
//  It XOR-accumulates data and parity, then flags parity and framing errors.
//  Sits after the link sampler, one bit per bit_valid strobe, and feeds the
//  word-level consumer.
// PARAMETERS
//  DATA_W      8   data bits per frame (>=1); bit counter is $clog2(DATA_W+1) wide
//  ODD_PARITY  0   0 = even parity (XOR of data+parity must be 0); 1 = odd (must be 1)
// PORTS
//  clk         in   1       rising-edge clock
//  rst         in   1       synchronous, active-high reset
//  bit_in      in   1       serial line value, sampled only when bit_valid=1
//  bit_valid   in   1       strobe: bit_in holds one new frame bit this cycle
//  data_out    out  DATA_W  last received word (bit0 = first data bit received)
//  data_valid  out  1       one-cycle pulse: data_out/parity_err/frame_err updated
//  parity_err  out  1       parity check failed for the word in data_out
//  frame_err   out  1       stop bit was 0 for the word in data_out
//  busy        out  1       1 whenever state != IDLE
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge, any state): state=IDLE, bit count=0, accumulator=0,
//    shift reg=0, data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0.
//    A frame in progress is discarded with no data_valid.
//  - Cycles with bit_valid=0 change nothing: state, count and accumulator hold.
//    Gaps of any length are allowed anywhere in a frame.
//  - FSM, advancing only on edges with bit_valid=1:
//    IDLE:   bit_in=0 is a start bit -> DATA, count=0, acc=0. bit_in=1 -> stay IDLE.
//    DATA:   shift bit_in into the shift reg MSB (shift right), acc^=bit_in, count++.
//            When count reaches DATA_W the state goes to PARITY.
//            After DATA_W bits, shreg[0] = the first bit received.
//    PARITY: perr_next = acc ^ bit_in ^ ODD_PARITY -> STOP.
//    STOP:   load data_out=shreg, parity_err=perr_next, frame_err=~bit_in.
//            Set data_valid=1 and go to IDLE.
//  - Latency: data_valid is high in the cycle right after the edge that samples the
//    stop bit, and deasserts one cycle later. It is never high for two consecutive
//    cycles.
//  - data_out, parity_err and frame_err hold until the next completed frame or a reset.
//  - A frame with a bad stop bit still completes: it is reported with frame_err=1,
//    data and parity_err are still reported, and the FSM returns to IDLE.
//    There is no resync hunting.
//  - Back-to-back frames: a start bit presented while data_valid=1 is accepted.
//    The FSM is already in IDLE, so there are no dead cycles between frames.
//  - A start bit is qualified only by bit_in=0 with bit_valid=1 in IDLE.
//    There is no mid-bit re-check.
//  - Total bit_valid strobes per frame: DATA_W+3.
//  - busy goes high in the cycle after the start-bit edge and low in the data_valid
//    cycle.
// TESTING (DATA_W=8 unless noted; the bits listed are the bit_in sequence on
//          consecutive bit_valid cycles)
//  1 Even parity, good frame: 0,1,0,1,0,0,1,0,1,0,1 (0xA5, p=0, stop=1)
//    -> one data_valid pulse; data_out=8'hA5, parity_err=0, frame_err=0.
//  2 Parity error: 0,1,1,1,0,0,0,0,0,0,1 (0x07, p=0) -> data_out=8'h07,
//    parity_err=1, frame_err=0. Repeat with ODD_PARITY=1 -> parity_err=0.
//  3 Framing error: 0x3C, p=0, stop=0 -> data_out=8'h3C, frame_err=1, parity_err=0.
//    The next good frame, 0x01 with p=1, reports frame_err=0.
//  4 Gaps plus idle 1s: five idle 1-bits, then frame 0xA5 with 0-3 random
//    bit_valid=0 cycles between strobes -> the same result as test 1, one pulse,
//    and busy stays high across the gaps.
//  5 Reset mid-frame: start bit plus 4 data bits, then rst for 1 cycle -> every
//    output is 0 the next cycle and there is no data_valid. A following frame 0x5A
//    with p=0 gives data_out=8'h5A and no errors.
//  6 Back-to-back: frames 0xFF (p=0) and 0x80 (p=1) with a continuous bit_valid
//    -> two pulses exactly 11 cycles apart, data 8'hFF then 8'h80, both error-free.

Source files
------------

// File: rtl/serial_parity_rx.sv
// serial_parity_rx: deserialises start/data/parity/stop frames, flags parity and framing errors
module serial_parity_rx #(
  parameter int DATA_W     = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic              acc_q;
  logic              perr_q;
  logic [DATA_W-1:0] shreg_q;
  assign busy = state_q != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= 1'b0;
      perr_q     <= 1'b0;
      shreg_q    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (bit_valid) begin
        case (state_q)
          IDLE: if (!bit_in) begin
            state_q <= DATA;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
          end
          DATA: begin
            shreg_q <= DATA_W'({bit_in, shreg_q} >> 1);
            acc_q   <= acc_q ^ bit_in;
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == LAST) state_q <= PARITY;
          end
          PARITY: begin
            perr_q  <= acc_q ^ bit_in ^ ODD_PARITY;
            state_q <= STOP;
          end
          STOP: begin
            data_out   <= shreg_q;
            parity_err <= perr_q;
            frame_err  <= ~bit_in;
            data_valid <= 1'b1;
            state_q    <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_serial_parity_rx.sv
// tb_serial_parity_rx: randomized and directed checks of serial_parity_rx against a frame-level model
module tb_serial_parity_rx;
  logic clk = 1'b0, rst = 1'b1, bit_in = 1'b1, bit_valid = 1'b0;
  logic [7:0] data_e, data_o;
  logic dv_e, perr_e, ferr_e, busy_e, dv_o, perr_o, ferr_o, busy_o;
  int n_chk = 0, n_fail = 0, cyc = 0;
  logic prev_dv = 1'b0;
  logic [7:0] qd[$], qod[$];
  logic qp[$], qf[$], qo[$];
  int qc[$];

  serial_parity_rx #(.DATA_W(8), .ODD_PARITY(1'b0)) dut_e (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .data_out(data_e),
    .data_valid(dv_e), .parity_err(perr_e), .frame_err(ferr_e), .busy(busy_e));
  serial_parity_rx #(.DATA_W(8), .ODD_PARITY(1'b1)) dut_o (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .data_out(data_o),
    .data_valid(dv_o), .parity_err(perr_o), .frame_err(ferr_o), .busy(busy_o));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dv_e) begin
      n_chk++;
      if (prev_dv) begin n_fail++; $display("FAIL dv_double got 1 exp 0 at cycle %0d", cyc); end
      qd.push_back(data_e); qp.push_back(perr_e); qf.push_back(ferr_e); qc.push_back(cyc);
    end
    if (dv_o) begin qod.push_back(data_o); qo.push_back(perr_o); end
    prev_dv = dv_e;
  end

  // Parity error iff the total count of ones in data+parity disagrees with the selected sense.
  function automatic logic model_perr(input logic [7:0] d, input logic p, input logic odd);
    return ((($countones(d) + int'(p)) % 2) == 1) != odd;
  endfunction

  task automatic clear_q();
    qd.delete(); qp.delete(); qf.delete(); qc.delete(); qod.delete(); qo.delete();
  endtask

  task automatic strobe(input logic b);
    bit_in = b; bit_valid = 1'b1;
    @(posedge clk); #1;
    bit_valid = 1'b0; bit_in = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    strobe(1'b0);
    for (int i = 0; i < 8; i++) strobe(d[i]);
    strobe(p);
    strobe(s);
  endtask

  task automatic drain();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; bit_valid = 1'b1; bit_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; bit_valid = 1'b0; bit_in = 1'b1;
    n_chk++; if (data_e !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h exp 00", data_e); end
    n_chk++; if ({dv_e, perr_e, ferr_e, busy_e} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got %b exp 0000", {dv_e, perr_e, ferr_e, busy_e}); end
    drain();
    clear_q();
  endtask

  task automatic test_even_good();
    clear_q();
    send_frame(8'hA5, 1'b0, 1'b1);
    n_chk++; if (dv_e !== 1'b1) begin n_fail++; $display("FAIL good_dv_latency got %b exp 1", dv_e); end
    n_chk++; if (busy_e !== 1'b0) begin n_fail++; $display("FAIL good_busy_at_dv got %b exp 0", busy_e); end
    @(negedge clk); @(negedge clk);
    n_chk++; if (dv_e !== 1'b0) begin n_fail++; $display("FAIL good_dv_width got %b exp 0", dv_e); end
    drain();
    n_chk++; if (qd.size() !== 1) begin n_fail++; $display("FAIL good_pulses got %0d exp 1", qd.size()); end
    else begin
      n_chk++; if (qd[0] !== 8'hA5) begin n_fail++; $display("FAIL good_data got %h exp a5", qd[0]); end
      n_chk++; if ({qp[0], qf[0]} !== {model_perr(8'hA5, 1'b0, 1'b0), 1'b0}) begin n_fail++; $display("FAIL good_errs got %b exp 00", {qp[0], qf[0]}); end
    end
  endtask

  task automatic test_parity_err();
    clear_q();
    send_frame(8'h07, 1'b0, 1'b1);
    drain();
    n_chk++; if (qd.size() !== 1 || qo.size() !== 1) begin n_fail++; $display("FAIL perr_pulses got %0d/%0d exp 1/1", qd.size(), qo.size()); end
    else begin
      n_chk++; if (qd[0] !== 8'h07 || qod[0] !== 8'h07) begin n_fail++; $display("FAIL perr_data got %h/%h exp 07/07", qd[0], qod[0]); end
      n_chk++; if (qp[0] !== 1'b1 || qf[0] !== 1'b0) begin n_fail++; $display("FAIL perr_even got p=%b f=%b exp p=1 f=0", qp[0], qf[0]); end
      n_chk++; if (qo[0] !== 1'b0) begin n_fail++; $display("FAIL perr_odd got %b exp 0", qo[0]); end
    end
    n_chk++; if (parity_err_hold() !== 1'b1) begin n_fail++; $display("FAIL perr_hold got %b exp 1", perr_e); end
  endtask

  function automatic logic parity_err_hold();
    return perr_e;
  endfunction

  task automatic test_frame_err();
    clear_q();
    send_frame(8'h3C, 1'b0, 1'b0);
    send_frame(8'h01, 1'b1, 1'b1);
    drain();
    n_chk++; if (qd.size() !== 2) begin n_fail++; $display("FAIL ferr_pulses got %0d exp 2", qd.size()); end
    else begin
      n_chk++; if (qd[0] !== 8'h3C || qf[0] !== 1'b1 || qp[0] !== 1'b0) begin n_fail++; $display("FAIL ferr_bad got d=%h f=%b p=%b exp d=3c f=1 p=0", qd[0], qf[0], qp[0]); end
      n_chk++; if (qd[1] !== 8'h01 || qf[1] !== 1'b0 || qp[1] !== 1'b0) begin n_fail++; $display("FAIL ferr_next got d=%h f=%b p=%b exp d=01 f=0 p=0", qd[1], qf[1], qp[1]); end
    end
  endtask

  task automatic test_gaps();
    logic [10:0] fr;
    int g;
    int busy_bad;
    clear_q();
    busy_bad = 0;
    fr = {1'b1, 1'b0, 8'hA5, 1'b0};
    for (int k = 0; k < 5; k++) begin
      repeat ($urandom_range(3, 0)) @(posedge clk);
      #1 strobe(1'b1);
      if (busy_e !== 1'b0) busy_bad++;
    end
    for (int i = 0; i < 11; i++) begin
      g = $urandom_range(3, 0);
      repeat (g) begin
        @(posedge clk); #1;
        if (i > 0 && busy_e !== 1'b1) busy_bad++;
      end
      strobe(fr[i]);
    end
    drain();
    n_chk++; if (busy_bad !== 0) begin n_fail++; $display("FAIL gaps_busy got %0d bad cycles exp 0", busy_bad); end
    n_chk++; if (qd.size() !== 1) begin n_fail++; $display("FAIL gaps_pulses got %0d exp 1", qd.size()); end
    else begin
      n_chk++; if (qd[0] !== 8'hA5 || qp[0] !== 1'b0 || qf[0] !== 1'b0) begin n_fail++; $display("FAIL gaps_result got d=%h p=%b f=%b exp d=a5 p=0 f=0", qd[0], qp[0], qf[0]); end
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    strobe(1'b0);
    for (int i = 0; i < 4; i++) strobe(1'b1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    n_chk++; if (data_e !== 8'h00 || data_o !== 8'h00) begin n_fail++; $display("FAIL rstmid_data got %h/%h exp 00/00", data_e, data_o); end
    n_chk++; if ({dv_e, perr_e, ferr_e, busy_e} !== 4'b0) begin n_fail++; $display("FAIL rstmid_flags got %b exp 0000", {dv_e, perr_e, ferr_e, busy_e}); end
    repeat (12) @(negedge clk);
    n_chk++; if (qd.size() !== 0) begin n_fail++; $display("FAIL rstmid_nodv got %0d exp 0", qd.size()); end
    send_frame(8'h5A, 1'b0, 1'b1);
    drain();
    n_chk++; if (qd.size() !== 1) begin n_fail++; $display("FAIL rstmid_pulses got %0d exp 1", qd.size()); end
    else begin
      n_chk++; if (qd[0] !== 8'h5A || qp[0] !== 1'b0 || qf[0] !== 1'b0) begin n_fail++; $display("FAIL rstmid_result got d=%h p=%b f=%b exp d=5a p=0 f=0", qd[0], qp[0], qf[0]); end
    end
  endtask

  task automatic test_back_to_back();
    clear_q();
    send_frame(8'hFF, 1'b0, 1'b1);
    send_frame(8'h80, 1'b1, 1'b1);
    drain();
    n_chk++; if (qd.size() !== 2) begin n_fail++; $display("FAIL b2b_pulses got %0d exp 2", qd.size()); end
    else begin
      n_chk++; if (qc[1] - qc[0] !== 11) begin n_fail++; $display("FAIL b2b_spacing got %0d exp 11", qc[1] - qc[0]); end
      n_chk++; if (qd[0] !== 8'hFF || qd[1] !== 8'h80) begin n_fail++; $display("FAIL b2b_data got %h,%h exp ff,80", qd[0], qd[1]); end
      n_chk++; if ({qp[0], qf[0], qp[1], qf[1]} !== 4'b0) begin n_fail++; $display("FAIL b2b_errs got %b exp 0000", {qp[0], qf[0], qp[1], qf[1]}); end
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic p, s;
    logic [10:0] fr;
    for (int k = 0; k < 40; k++) begin
      clear_q();
      d = 8'($urandom); p = 1'($urandom); s = ($urandom_range(3, 0) != 0);
      fr = {s, p, d, 1'b0};
      for (int i = 0; i < 11; i++) begin
        repeat ($urandom_range(2, 0)) @(posedge clk);
        #1 strobe(fr[i]);
      end
      drain();
      n_chk++; if (qd.size() !== 1 || qo.size() !== 1) begin n_fail++; $display("FAIL rand_pulses[%0d] got %0d/%0d exp 1/1", k, qd.size(), qo.size()); end
      else begin
        n_chk++; if (qd[0] !== d || qod[0] !== d) begin n_fail++; $display("FAIL rand_data[%0d] got %h/%h exp %h", k, qd[0], qod[0], d); end
        n_chk++; if (qp[0] !== model_perr(d, p, 1'b0) || qo[0] !== model_perr(d, p, 1'b1)) begin n_fail++; $display("FAIL rand_perr[%0d] got %b/%b exp %b/%b", k, qp[0], qo[0], model_perr(d, p, 1'b0), model_perr(d, p, 1'b1)); end
        n_chk++; if (qf[0] !== !s) begin n_fail++; $display("FAIL rand_ferr[%0d] got %b exp %b", k, qf[0], !s); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_even_good();
    test_parity_err();
    test_frame_err();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
